// File: rtl/turtle_io_pkg.sv
`default_nettype none
// ============================================================================
// Package : turtle_io_pkg
// Brief   : Register-map offsets, CTRL bit indices and seven-segment decode.
// Rev     : 1.0 - initial release
// ============================================================================
package turtle_io_pkg;

  localparam int CTRL_DISP_EN_BIT = 0;
  localparam int LED_OFF          = 0;

  // Offsets pack the register groups back to back from the window base.
  function automatic int disp_off(input int num_leds, input int data_w);
    return LED_OFF + num_leds / data_w;
  endfunction

  function automatic int ctrl_off(input int num_leds, input int num_digits, input int data_w);
    return disp_off(num_leds, data_w) + (4 * num_digits) / data_w;
  endfunction

  function automatic int sw_off(input int num_leds, input int num_digits, input int data_w);
    return ctrl_off(num_leds, num_digits, data_w) + 1;
  endfunction

  function automatic int evt_off(input int num_leds, input int num_digits, input int num_sw,
                                 input int data_w);
    return sw_off(num_leds, num_digits, data_w) + num_sw / data_w;
  endfunction

  // Active-low segments, bit 0 = a .. bit 6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sw_debouncer.sv
`default_nettype none
// ============================================================================
// Module : sw_debouncer
// Brief  : Two-flop synchroniser, shared sample tick, two-sample agreement.
// Rev    : 1.0 - initial release
// ============================================================================
module sw_debouncer #(
  parameter int NUM_SW       = 16,
  parameter int DEBOUNCE_DIV = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw_db,
  output logic [NUM_SW-1:0] sw_rise
);

  localparam int CNT_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

  logic [NUM_SW-1:0] r_sync1;
  logic [NUM_SW-1:0] r_sync2;
  logic [NUM_SW-1:0] r_sample;
  logic [NUM_SW-1:0] r_db;
  logic [NUM_SW-1:0] r_rise;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_tick;

  assign w_tick  = (r_cnt == CNT_W'(DEBOUNCE_DIV - 1));
  assign sw_db   = r_db;
  assign sw_rise = r_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_sample <= '0;
      r_db     <= '0;
      r_rise   <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
      r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
      r_rise  <= '0;
      if (w_tick) begin
        r_sample <= r_sync2;
        // Where the new and previous samples agree take that value, else hold.
        r_db     <= (r_sync2 & r_sample) | (r_db & (r_sync2 | r_sample));
        r_rise   <= r_sync2 & r_sample & ~r_db;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mmio_display_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mmio_display_io_ctrl
// Brief  : MMIO LEDs, multiplexed hex display, debounced switches, edge flags.
// Rev    : 1.0 - initial release
// ============================================================================
module mmio_display_io_ctrl
  import turtle_io_pkg::*;
#(
  parameter int                  DATA_W       = 8,
  parameter int                  D_ADDR_W     = 12,
  parameter logic [D_ADDR_W-1:0] BASE_ADDR    = 12'hFF0,
  parameter int                  NUM_LEDS     = 16,
  parameter int                  NUM_SW       = 16,
  parameter int                  NUM_DIGITS   = 4,
  parameter int                  REFRESH_DIV  = 100000,
  parameter int                  DEBOUNCE_DIV = 500000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [D_ADDR_W-1:0]     data_addr,
  input  logic                    write_enable,
  input  logic [DATA_W-1:0]       write_data,
  output logic [DATA_W-1:0]       read_data,
  output logic                    io_hit,
  input  logic [NUM_SW-1:0]       sw,
  output logic [NUM_LEDS-1:0]     led,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  input  logic                    debug_enable,
  input  logic [4*NUM_DIGITS-1:0] debug_value
);

  localparam int LB       = NUM_LEDS / DATA_W;
  localparam int DB       = (4 * NUM_DIGITS) / DATA_W;
  localparam int SB       = NUM_SW / DATA_W;
  localparam int DISP_OFF = disp_off(NUM_LEDS, DATA_W);
  localparam int CTRL_OFF = ctrl_off(NUM_LEDS, NUM_DIGITS, DATA_W);
  localparam int SW_OFF   = sw_off(NUM_LEDS, NUM_DIGITS, DATA_W);
  localparam int EVT_OFF  = evt_off(NUM_LEDS, NUM_DIGITS, NUM_SW, DATA_W);
  localparam int REF_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W    = $clog2(NUM_DIGITS);

  logic [DATA_W-1:0]       r_led [LB];
  logic [DATA_W-1:0]       r_disp [DB];
  logic                    r_ctrl_en;
  logic [DATA_W-1:0]       r_evt;
  logic [DATA_W-1:0]       r_read_data;
  logic [REF_W-1:0]        r_refresh_cnt;
  logic [IDX_W-1:0]        r_digit_idx;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;

  logic [3:0]              w_off;
  logic                    w_wr;
  logic                    w_evt_wr;
  logic [DATA_W-1:0]       w_rd_mux;
  logic [NUM_SW-1:0]       w_sw_db;
  logic [NUM_SW-1:0]       w_sw_rise;
  logic [4*NUM_DIGITS-1:0] w_disp_flat;
  logic [4*NUM_DIGITS-1:0] w_nib_src;
  logic [3:0]              w_nibble;
  logic                    w_refresh_tc;

  // The window is 16-aligned, so the low address nibble is the offset.
  assign io_hit   = (data_addr[D_ADDR_W-1:4] == BASE_ADDR[D_ADDR_W-1:4]);
  assign w_off    = data_addr[3:0];
  assign w_wr     = write_enable & io_hit;
  assign w_evt_wr = w_wr & (w_off == 4'(EVT_OFF));

  sw_debouncer #(
    .NUM_SW       (NUM_SW),
    .DEBOUNCE_DIV (DEBOUNCE_DIV)
  ) u_sw_debouncer (
    .clk     (clk),
    .reset   (reset),
    .sw_raw  (sw),
    .sw_db   (w_sw_db),
    .sw_rise (w_sw_rise)
  );

  generate
    for (genvar gi = 0; gi < LB; gi++) begin : g_led_out
      assign led[gi*DATA_W +: DATA_W] = r_led[gi];
    end
    for (genvar gi = 0; gi < DB; gi++) begin : g_disp_flat
      assign w_disp_flat[gi*DATA_W +: DATA_W] = r_disp[gi];
    end
    if (NUM_SW > DATA_W) begin : g_unused_rise
      logic w_unused_rise;
      assign w_unused_rise = ^w_sw_rise[NUM_SW-1:DATA_W];
    end
  endgenerate

  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < LB; i++)
      if (w_off == 4'(LED_OFF + i)) w_rd_mux = r_led[i];
    for (int i = 0; i < DB; i++)
      if (w_off == 4'(DISP_OFF + i)) w_rd_mux = r_disp[i];
    if (w_off == 4'(CTRL_OFF)) w_rd_mux = DATA_W'(r_ctrl_en);
    for (int i = 0; i < SB; i++)
      if (w_off == 4'(SW_OFF + i)) w_rd_mux = w_sw_db[i*DATA_W +: DATA_W];
    if (w_off == 4'(EVT_OFF)) w_rd_mux = r_evt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LB; i++) r_led[i] <= '0;
      for (int i = 0; i < DB; i++) r_disp[i] <= '0;
      r_ctrl_en   <= 1'b1;
      r_evt       <= '0;
      r_read_data <= '0;
    end else begin
      r_read_data <= io_hit ? w_rd_mux : '0;
      if (w_wr) begin
        for (int i = 0; i < LB; i++)
          if (w_off == 4'(LED_OFF + i)) r_led[i] <= write_data;
        for (int i = 0; i < DB; i++)
          if (w_off == 4'(DISP_OFF + i)) r_disp[i] <= write_data;
        if (w_off == 4'(CTRL_OFF)) r_ctrl_en <= write_data[CTRL_DISP_EN_BIT];
      end
      // Applying the clear before OR-ing in new edges lets a same-cycle set win.
      r_evt <= (r_evt & ~(w_evt_wr ? write_data : '0)) | w_sw_rise[DATA_W-1:0];
    end
  end

  assign read_data    = r_read_data;
  assign w_refresh_tc = (r_refresh_cnt == REF_W'(REFRESH_DIV - 1));
  assign w_nib_src    = debug_enable ? debug_value : w_disp_flat;
  assign w_nibble     = w_nib_src[r_digit_idx*4 +: 4];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= '0;
      r_an          <= '1;
      r_seg         <= 7'h7F;
    end else begin
      r_refresh_cnt <= w_refresh_tc ? '0 : r_refresh_cnt + 1'b1;
      if (w_refresh_tc)
        r_digit_idx <= (r_digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_digit_idx + 1'b1;
      if (!r_ctrl_en && !debug_enable) begin
        r_an  <= '1;
        r_seg <= 7'h7F;
      end else begin
        r_an  <= ~(NUM_DIGITS'(1) << r_digit_idx);
        r_seg <= hex_to_seg(w_nibble);
      end
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_mmio_display_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_mmio_display_io_ctrl
// Brief  : Directed plus random stimulus against a cycle-level reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mmio_display_io_ctrl;

  localparam int BASE   = 12'hFF0;
  localparam int ND     = 4;
  localparam int RDIV   = 4;
  localparam int SETTLE = 10;
  localparam int LB = 2, DB = 2, CTRL = 4, SWO = 5, EVT = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] data_addr = '0;
  logic        write_enable = 1'b0;
  logic [7:0]  write_data = '0;
  logic [7:0]  read_data;
  logic        io_hit;
  logic [15:0] sw = '0;
  logic [15:0] led;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        debug_enable = 1'b0;
  logic [15:0] debug_value = '0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_led [LB];
  logic [7:0]  m_disp [DB];
  logic        m_ctrl;
  logic [7:0]  m_evt;
  logic [15:0] m_db;
  logic [15:0] m_sw_last;
  int          m_stable;
  int          m_k;
  bit          m_chk_rd = 1'b1;

  always #5 clk = ~clk;

  mmio_display_io_ctrl #(
    .REFRESH_DIV  (RDIV),
    .DEBOUNCE_DIV (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_addr    (data_addr),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_data    (read_data),
    .io_hit       (io_hit),
    .sw           (sw),
    .led          (led),
    .seg          (seg),
    .an           (an),
    .debug_enable (debug_enable),
    .debug_value  (debug_value)
  );

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LB; i++) m_led[i] = '0;
    for (int i = 0; i < DB; i++) m_disp[i] = '0;
    m_ctrl = 1'b1; m_evt = '0; m_db = '0; m_sw_last = '0;
    m_stable = SETTLE + 1; m_k = 0;
  endtask

  function automatic logic [7:0] model_read(input int off);
    if (off < LB)   return m_led[off];
    if (off < CTRL) return m_disp[off-LB];
    if (off == CTRL) return {7'b0, m_ctrl};
    if (off < EVT)  return m_db[(off-SWO)*8 +: 8];
    if (off == EVT) return m_evt;
    return 8'h00;
  endfunction

  // One clock: predict outputs from pre-edge state, then advance the model.
  task automatic tick();
    logic [7:0] e_rd; logic [3:0] e_an; logic [6:0] e_seg; logic [3:0] nib;
    logic [15:0] disp_flat;
    bit hit, rd_ok; int off, idx;
    #1;
    hit = (int'(data_addr) >= BASE) && (int'(data_addr) <= BASE + 15);
    chk("io_hit", io_hit, hit);
    off = int'(data_addr) - BASE;
    if (!reset) begin
      if (sw != m_sw_last) begin
        m_stable = 0; m_sw_last = sw;
      end else if (m_stable < SETTLE) begin
        m_stable++;
        if (m_stable == SETTLE) begin
          m_evt = m_evt | (sw[7:0] & ~m_db[7:0]);
          m_db  = sw;
        end
      end
    end
    rd_ok = !(hit && off >= SWO && off <= EVT && m_stable < SETTLE);
    e_rd  = hit ? model_read(off) : 8'h00;
    idx   = (m_k / RDIV) % ND;
    disp_flat = {m_disp[1], m_disp[0]};
    if (!m_ctrl && !debug_enable) begin
      e_an = 4'hF; e_seg = 7'h7F;
    end else begin
      nib   = debug_enable ? debug_value[idx*4 +: 4] : disp_flat[idx*4 +: 4];
      e_an  = ~(4'b1 << idx);
      e_seg = seg_ref(nib);
    end
    @(posedge clk);
    if (reset) begin
      model_reset();
      e_an = 4'hF; e_seg = 7'h7F; e_rd = 8'h00; rd_ok = 1'b1;
    end else begin
      m_k++;
      if (write_enable && hit) begin
        if (off < LB) m_led[off] = write_data;
        else if (off < CTRL) m_disp[off-LB] = write_data;
        else if (off == CTRL) m_ctrl = write_data[0];
        else if (off == EVT) m_evt = m_evt & ~write_data;
      end
    end
    #1;
    chk("an", an, e_an);
    chk("seg", seg, e_seg);
    chk("led", led, {m_led[1], m_led[0]});
    if (rd_ok && m_chk_rd) chk("read_data", read_data, e_rd);
  endtask

  task automatic bus(input int addr, input bit we, input logic [7:0] wd);
    data_addr = 12'(addr); write_enable = we; write_data = wd;
    tick();
  endtask

  initial begin
    bit saw_set;
    model_reset();
    tick(); tick();
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_rd", read_data, 8'h00);
    reset = 1'b0;
    bus(BASE + CTRL, 0, 0);
    chk("rst_ctrl", read_data, 8'h01);

    // LED writes and readback
    bus(BASE + 0, 1, 8'hA5);
    bus(BASE + 1, 1, 8'h3C);
    chk("led_val", led, 16'h3CA5);
    bus(BASE + 1, 0, 0);
    chk("led_rd", read_data, 8'h3C);

    // Display scan of 4,3,2,1 across a few wraps
    bus(BASE + 2, 1, 8'h21);
    bus(BASE + 3, 1, 8'h43);
    data_addr = 12'h100; write_enable = 0;
    for (int i = 0; i < 3 * ND * RDIV; i++) tick();

    // Blanking, then debug override
    bus(BASE + CTRL, 1, 8'h00);
    tick();
    chk("blank_an", an, 4'hF);
    chk("blank_seg", seg, 7'h7F);
    debug_value = 16'hBEEF; debug_enable = 1'b1;
    data_addr = 12'h100; write_enable = 0;
    for (int i = 0; i < 2 * ND * RDIV; i++) tick();
    debug_enable = 1'b0;
    bus(BASE + CTRL, 1, 8'h01);

    // One-cycle glitch must be rejected, long hold must register
    sw[0] = 1'b1; bus(BASE + SWO, 0, 0);
    sw[0] = 1'b0;
    for (int i = 0; i < 12; i++) bus(BASE + EVT, 0, 0);
    chk("glitch_evt", read_data, 8'h00);
    bus(BASE + SWO, 0, 0);
    chk("glitch_sw", read_data, 8'h00);
    sw[0] = 1'b1;
    for (int i = 0; i < 12; i++) bus(BASE + SWO, 0, 0);
    chk("sw_byte0", read_data, 8'h01);
    bus(BASE + EVT, 1, 8'h01);
    chk("evt_set", read_data, 8'h01);
    bus(BASE + EVT, 0, 0);
    chk("evt_clr", read_data, 8'h00);

    // Continuous W1C across a fresh rising edge: the set must still be seen
    sw[0] = 1'b0;
    for (int i = 0; i < 12; i++) bus(BASE + EVT, 0, 0);
    saw_set = 1'b0;
    m_chk_rd = 1'b0;
    sw[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus(BASE + EVT, 1, 8'h01);
      if (read_data[0] === 1'b1) saw_set = 1'b1;
    end
    m_chk_rd = 1'b1;
    chk("set_beats_w1c", 32'(saw_set), 32'd1);

    // Out-of-window accesses
    bus(BASE - 1, 1, 8'hFF);
    chk("below_hit", io_hit, 1'b0);
    chk("below_rd", read_data, 8'h00);
    bus(BASE + 16, 1, 8'hFF);
    chk("above_rd", read_data, 8'h00);
    chk("above_led", led, 16'h3CA5);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      if (i % 16 == 0) sw = 16'($urandom);
      if (i % 32 == 0) begin
        debug_enable = ($urandom_range(0, 3) == 0);
        debug_value  = 16'($urandom);
      end
      r = $urandom_range(0, 19);
      data_addr    = (r < 16) ? 12'(BASE + r) : 12'($urandom);
      write_enable = $urandom_range(0, 1) == 1;
      write_data   = 8'($urandom);
      if (int'(data_addr) == BASE + EVT && m_stable < SETTLE) write_enable = 1'b0;
      tick();
    end

    // Reset mid-scan
    debug_enable = 1'b0;
    bus(BASE + 0, 1, 8'h5A);
    reset = 1'b1;
    bus(BASE + 1, 1, 8'hFF);
    chk("rst_mid_an", an, 4'hF);
    chk("rst_mid_seg", seg, 7'h7F);
    chk("rst_mid_led", led, 16'h0000);
    reset = 1'b0;
    sw = '0;
    data_addr = 12'h100; write_enable = 0;
    for (int i = 0; i < 2 * ND * RDIV; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
